// File: rtl/pass_checker_lockout.sv
// Password-check engine for the door lock: compares the entered code against the stored password,
// holds unlock for a bounded time, counts consecutive failures and enters a timed lockout.
module pass_checker_lockout #(
    parameter int                    PW_WIDTH       = 16,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    UNLOCK_CYCLES  = 8,
    parameter int                    LOCKOUT_CYCLES = 16,
    parameter logic [PW_WIDTH-1:0]   DEFAULT_PW     = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PW_WIDTH-1:0]                pw_16bit,
    input  logic                               enb_cmp,
    input  logic                               enb_chg,
    output logic                               enb_lock,
    output logic                               gen_rst,
    output logic                               locked_out,
    output logic                               pw_updated,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt
);

    localparam int FW    = $clog2(MAX_TRIES + 1);
    localparam int MAX_C = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    // Guard the degenerate case where both durations are 1 cycle.
    localparam int TW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OPEN    = 2'd1;
    localparam logic [1:0] S_LOCKOUT = 2'd2;

    logic [1:0]          state_q,      state_d;
    logic [FW-1:0]       fail_q,       fail_d;
    logic [TW-1:0]       timer_q,      timer_d;
    logic [PW_WIDTH-1:0] pw_reg_q,     pw_reg_d;
    logic                cmp_prev_q,   cmp_prev_d;
    logic                enb_lock_q,   enb_lock_d;
    logic                gen_rst_q,    gen_rst_d;
    logic                locked_out_q, locked_out_d;
    logic                pw_upd_q,     pw_upd_d;
    logic                cmp_evt;

    // Edges arriving outside IDLE are consumed here and never replayed.
    assign cmp_evt = enb_cmp & ~cmp_prev_q;

    always_comb begin
        state_d    = state_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        pw_reg_d   = pw_reg_q;
        cmp_prev_d = enb_cmp;
        gen_rst_d  = 1'b0;
        pw_upd_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmp_evt) begin
                    if (pw_16bit == pw_reg_q) begin
                        state_d = S_OPEN;
                        fail_d  = '0;
                        timer_d = TW'(UNLOCK_CYCLES - 1);
                    end else if (fail_q == FW'(MAX_TRIES - 1)) begin
                        state_d   = S_LOCKOUT;
                        fail_d    = FW'(MAX_TRIES);
                        timer_d   = TW'(LOCKOUT_CYCLES - 1);
                        gen_rst_d = 1'b1;
                    end else begin
                        fail_d = fail_q + 1'b1;
                    end
                end
            end
            S_OPEN: begin
                if (enb_chg) begin
                    pw_reg_d = pw_16bit;
                    pw_upd_d = 1'b1;
                end
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        enb_lock_d   = (state_d == S_OPEN);
        locked_out_d = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fail_q       <= '0;
            timer_q      <= '0;
            pw_reg_q     <= DEFAULT_PW;
            cmp_prev_q   <= 1'b0;
            enb_lock_q   <= 1'b0;
            gen_rst_q    <= 1'b0;
            locked_out_q <= 1'b0;
            pw_upd_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fail_q       <= fail_d;
            timer_q      <= timer_d;
            pw_reg_q     <= pw_reg_d;
            cmp_prev_q   <= cmp_prev_d;
            enb_lock_q   <= enb_lock_d;
            gen_rst_q    <= gen_rst_d;
            locked_out_q <= locked_out_d;
            pw_upd_q     <= pw_upd_d;
        end
    end

    assign enb_lock   = enb_lock_q;
    assign gen_rst    = gen_rst_q;
    assign locked_out = locked_out_q;
    assign pw_updated = pw_upd_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_pass_checker_lockout.sv
// Directed bench for pass_checker_lockout at default parameters; expectations are hand-computed.
module tb_pass_checker_lockout;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pw_16bit;
    logic        enb_cmp;
    logic        enb_chg;
    logic        enb_lock;
    logic        gen_rst;
    logic        locked_out;
    logic        pw_updated;
    logic [1:0]  fail_cnt;

    int total = 0;
    int bad   = 0;
    int n;
    int g;

    pass_checker_lockout dut (
        .clk        (clk),
        .reset      (reset),
        .pw_16bit   (pw_16bit),
        .enb_cmp    (enb_cmp),
        .enb_chg    (enb_chg),
        .enb_lock   (enb_lock),
        .gen_rst    (gen_rst),
        .locked_out (locked_out),
        .pw_updated (pw_updated),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [15:0] pw);
        pw_16bit = pw;
        enb_cmp  = 1'b1;
        tick();
        enb_cmp  = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            if (!enb_lock && !locked_out) break;
            tick();
        end
        chk(tag, {30'd0, enb_lock, locked_out}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; pw_16bit = 16'h1234; enb_cmp = 1'b1; enb_chg = 1'b0;
        #1;
        repeat (3) tick();
        chk("rst_outputs", {28'd0, enb_lock, gen_rst, locked_out, pw_updated}, 32'd0);
        chk("rst_fail", fail_cnt, 0);
        reset = 1'b0; enb_cmp = 1'b0;
        tick();
        chk("post_rst_fail", fail_cnt, 0);

        // Three mismatches: the third enters lockout.
        pulse(16'h1234);
        chk("fail1", fail_cnt, 1);
        pulse(16'h1234);
        chk("fail2", fail_cnt, 2);
        enb_cmp = 1'b1;
        tick();
        chk("lk_gen_rst", gen_rst, 1);
        chk("lk_locked", locked_out, 1);
        chk("lk_fail3", fail_cnt, 3);
        // Hammer compares with the default password and a change request while locked.
        n = 1; g = 1;
        pw_16bit = 16'h0000; enb_chg = 1'b1;
        for (int i = 0; i < 40; i++) begin
            enb_cmp  = ~enb_cmp;
            pw_16bit = (i % 4 < 2) ? 16'h0000 : 16'hBEEF;
            tick();
            if (!locked_out) break;
            n++;
            if (gen_rst) g++;
            if (fail_cnt != 2'd3) chk("lk_fail_hold", fail_cnt, 3);
        end
        enb_cmp = 1'b0; enb_chg = 1'b0;
        chk("lk_len", n, 16);
        chk("lk_gen_rst_len", g, 1);
        chk("lk_fail_clr", fail_cnt, 0);
        chk("lk_no_unlock", enb_lock, 0);
        tick();
        chk("lk_idle_lock", enb_lock, 0);

        // Change request in IDLE must be ignored.
        pw_16bit = 16'hBEEF; enb_chg = 1'b1;
        tick();
        enb_chg = 1'b0;
        tick();
        chk("idle_chg_pulse", pw_updated, 0);

        // Two failures, then a match held high for 20 cycles: one unlock of 8 cycles.
        pulse(16'h1234);
        pulse(16'h1234);
        chk("pre_match_fail", fail_cnt, 2);
        pw_16bit = 16'h0000; enb_cmp = 1'b1;
        tick();
        chk("match_lock", enb_lock, 1);
        chk("match_fail_clr", fail_cnt, 0);
        n = 1;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (enb_lock) n++;
        end
        chk("unlock_len", n, 8);
        chk("held_no_relock", enb_lock, 0);
        enb_cmp = 1'b0;
        tick();

        // Password change in OPEN.
        pulse(16'h0000);
        chk("open2", enb_lock, 1);
        pw_16bit = 16'hBEEF; enb_chg = 1'b1;
        tick();
        enb_chg = 1'b0;
        chk("chg_pulse", pw_updated, 1);
        tick();
        chk("chg_pulse_end", pw_updated, 0);
        wait_idle("open2_end");
        pulse(16'h0000);
        chk("old_pw_fails", fail_cnt, 1);
        chk("old_pw_locked", enb_lock, 0);
        pulse(16'hBEEF);
        chk("new_pw_opens", enb_lock, 1);
        chk("new_pw_fail_clr", fail_cnt, 0);

        // Reset mid-OPEN after another change: password reverts to default.
        pw_16bit = 16'h1111; enb_chg = 1'b1;
        tick();
        enb_chg = 1'b0;
        chk("chg2_pulse", pw_updated, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_open_lock", enb_lock, 0);
        chk("rst_open_upd", pw_updated, 0);
        pulse(16'h0000);
        chk("pw_reverted", enb_lock, 1);
        wait_idle("open3_end");

        // Reset on lockout cycle 5.
        pulse(16'h1234);
        pulse(16'h1234);
        enb_cmp = 1'b1;
        tick();
        enb_cmp = 1'b0;
        repeat (4) tick();
        chk("lk5_locked", locked_out, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("lk5_rst_locked", locked_out, 0);
        chk("lk5_rst_fail", fail_cnt, 0);
        chk("lk5_rst_gen", gen_rst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
